brick_hit_ctrl: RTL and testbench

//  Per-frame ball/brick collision controller, downstream consumer of the brick map.
//  On each start strobe it latches the ball position and direction. It then probes up to three map cells

---
 rtl/brick_hit_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_brick_hit_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_hit_ctrl.sv
// Per-frame ball/brick collision controller: probes up to three map cells around the
// ball's leading corner, then issues clear/pull-up commands and reports bounce and score.
module brick_hit_ctrl #(
  parameter int ROWS    = 10,
  parameter int COLS    = 20,
  parameter int X_OFF   = 0,
  parameter int Y_OFF   = 32,
  parameter int CELL_W  = 32,
  parameter int CELL_H  = 16,
  parameter int BALL_SZ = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [9:0]      ball_x,
  input  logic [9:0]      ball_y,
  input  logic            dx_neg,
  input  logic            dy_neg,
  input  logic [3:0]      cell_kind,
  output logic            map_en,
  output logic [1:0]      map_func,
  output logic [ROWS-1:0] map_row,
  output logic [COLS-1:0] map_col,
  output logic            busy,
  output logic            done,
  output logic            flip_x,
  output logic            flip_y,
  output logic [3:0]      hit_kind,
  output logic [3:0]      score_inc
);

  localparam int CW_SH = $clog2(CELL_W);
  localparam int CH_SH = $clog2(CELL_H);

  typedef enum logic [3:0] {
    IDLE, PROBE_H, PROBE_V, PROBE_D, CLR_H, CLR_V, CLR_D, PULL, DONE
  } state_t;

  state_t state_reg, state_next;

  function automatic logic [4:0] kind_pts(input logic [3:0] k);
    case (k)
      4'b0001: return 5'd1;
      4'b0010: return 5'd5;
      4'b1000: return 5'd2;
      default: return 5'd0;
    endcase
  endfunction

  // Pixel coordinates: index 0 is the leading edge, index 1 the centre.
  logic [1:0][10:0]     x_pix, y_pix;
  logic [1:0][COLS-1:0] col_oh;
  logic [1:0][ROWS-1:0] row_oh;

  assign x_pix[0] = dx_neg ? {1'b0, ball_x} : {1'b0, ball_x} + 11'(BALL_SZ - 1);
  assign y_pix[0] = dy_neg ? {1'b0, ball_y} : {1'b0, ball_y} + 11'(BALL_SZ - 1);
  assign x_pix[1] = {1'b0, ball_x} + 11'(BALL_SZ / 2 - 1);
  assign y_pix[1] = {1'b0, ball_y} + 11'(BALL_SZ / 2 - 1);

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [11:0] x_rel, y_rel;
      logic [10:0] x_idx, y_idx;
      // Bit 11 of the difference flags a coordinate left of / above the field.
      assign x_rel = {1'b0, x_pix[gi]} - 12'(X_OFF);
      assign y_rel = {1'b0, y_pix[gi]} - 12'(Y_OFF);
      assign x_idx = x_rel[10:0] >> CW_SH;
      assign y_idx = y_rel[10:0] >> CH_SH;
      for (gj = 0; gj < COLS; gj++) begin : g_col
        assign col_oh[gi][gj] = !x_rel[11] && (x_idx == 11'(gj));
      end
      for (gj = 0; gj < ROWS; gj++) begin : g_row
        assign row_oh[gi][gj] = !y_rel[11] && (y_idx == 11'(gj));
      end
    end
  endgenerate

  // A cell with either index outside the field selects nothing at all.
  logic            h_ok, v_ok, d_ok;
  logic [ROWS-1:0] h_row_calc, v_row_calc, d_row_calc;
  logic [COLS-1:0] h_col_calc, v_col_calc, d_col_calc;

  assign h_ok = (|row_oh[1]) && (|col_oh[0]);
  assign v_ok = (|row_oh[0]) && (|col_oh[1]);
  assign d_ok = (|row_oh[0]) && (|col_oh[0]);
  assign h_row_calc = h_ok ? row_oh[1] : '0;
  assign h_col_calc = h_ok ? col_oh[0] : '0;
  assign v_row_calc = v_ok ? row_oh[0] : '0;
  assign v_col_calc = v_ok ? col_oh[1] : '0;
  assign d_row_calc = d_ok ? row_oh[0] : '0;
  assign d_col_calc = d_ok ? col_oh[0] : '0;

  logic [ROWS-1:0] h_row_reg, v_row_reg, d_row_reg;
  logic [COLS-1:0] h_col_reg, v_col_reg, d_col_reg;
  logic [3:0]      kind_h_reg, kind_v_reg, kind_d_reg;

  logic            map_en_reg, map_en_next;
  logic [1:0]      map_func_reg, map_func_next;
  logic [ROWS-1:0] map_row_reg, map_row_next;
  logic [COLS-1:0] map_col_reg, map_col_next;
  logic            busy_reg, busy_next, done_reg, done_next;
  logic            flip_x_reg, flip_x_next, flip_y_reg, flip_y_next;
  logic [3:0]      hit_kind_reg, hit_kind_next, score_reg, score_next;

  // Result evaluation; in PROBE_D the diagonal kind comes straight from the map.
  logic       d_dup, v_dup, d_valid;
  logic [3:0] kd_fresh, kd;
  logic       clr_h, clr_v, clr_d, pull;
  logic [4:0] pts_h, pts_v, pts_d, pts_sum;
  logic [3:0] score_sat;

  assign d_valid  = |d_row_reg;
  assign d_dup    = ((d_row_reg == h_row_reg) && (d_col_reg == h_col_reg)) ||
                    ((d_row_reg == v_row_reg) && (d_col_reg == v_col_reg));
  assign kd_fresh = (d_valid && !d_dup && (kind_h_reg == 4'd0) && (kind_v_reg == 4'd0))
                    ? cell_kind : 4'd0;
  assign kd       = (state_reg == PROBE_D) ? kd_fresh : kind_d_reg;
  // A ball sitting inside one cell probes it twice; it is cleared and scored only once.
  assign v_dup    = (v_row_reg == h_row_reg) && (v_col_reg == h_col_reg);

  assign pts_h = kind_pts(kind_h_reg);
  assign pts_v = v_dup ? 5'd0 : kind_pts(kind_v_reg);
  assign pts_d = kind_pts(kd);
  assign clr_h = pts_h != 5'd0;
  assign clr_v = pts_v != 5'd0;
  assign clr_d = pts_d != 5'd0;
  assign pull  = (clr_h && kind_h_reg == 4'b1000) || (clr_v && kind_v_reg == 4'b1000) ||
                 (clr_d && kd == 4'b1000);
  assign pts_sum   = pts_h + pts_v + pts_d;
  assign score_sat = (pts_sum > 5'd15) ? 4'd15 : pts_sum[3:0];

  state_t after_p, after_h, after_v, after_d;
  assign after_d = pull  ? PULL  : DONE;
  assign after_v = clr_d ? CLR_D : after_d;
  assign after_h = clr_v ? CLR_V : after_v;
  assign after_p = clr_h ? CLR_H : after_h;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    state_next = start ? PROBE_H : IDLE;
      PROBE_H: state_next = PROBE_V;
      PROBE_V: state_next = PROBE_D;
      PROBE_D: state_next = after_p;
      CLR_H:   state_next = after_h;
      CLR_V:   state_next = after_v;
      CLR_D:   state_next = after_d;
      PULL:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    map_en_next   = 1'b0;
    map_func_next = 2'b00;
    map_row_next  = '0;
    map_col_next  = '0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    flip_x_next   = 1'b0;
    flip_y_next   = 1'b0;
    hit_kind_next = 4'd0;
    score_next    = 4'd0;
    unique case (state_next)
      PROBE_H: begin
        busy_next    = 1'b1;
        map_row_next = (state_reg == IDLE) ? h_row_calc : h_row_reg;
        map_col_next = (state_reg == IDLE) ? h_col_calc : h_col_reg;
      end
      PROBE_V: begin
        busy_next    = 1'b1;
        map_row_next = v_row_reg;
        map_col_next = v_col_reg;
      end
      PROBE_D: begin
        busy_next    = 1'b1;
        map_row_next = d_row_reg;
        map_col_next = d_col_reg;
      end
      CLR_H: begin
        busy_next    = 1'b1;
        map_en_next  = 1'b1;
        map_row_next = h_row_reg;
        map_col_next = h_col_reg;
      end
      CLR_V: begin
        busy_next    = 1'b1;
        map_en_next  = 1'b1;
        map_row_next = v_row_reg;
        map_col_next = v_col_reg;
      end
      CLR_D: begin
        busy_next    = 1'b1;
        map_en_next  = 1'b1;
        map_row_next = d_row_reg;
        map_col_next = d_col_reg;
      end
      PULL: begin
        busy_next     = 1'b1;
        map_en_next   = 1'b1;
        map_func_next = 2'b11;
      end
      DONE: begin
        done_next     = 1'b1;
        flip_x_next   = (kind_h_reg != 4'd0) || (kd != 4'd0);
        flip_y_next   = (kind_v_reg != 4'd0) || (kd != 4'd0);
        hit_kind_next = kind_h_reg | kind_v_reg | kd;
        score_next    = score_sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      map_en_reg   <= 1'b0;
      map_func_reg <= 2'b00;
      map_row_reg  <= '0;
      map_col_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      flip_x_reg   <= 1'b0;
      flip_y_reg   <= 1'b0;
      hit_kind_reg <= 4'd0;
      score_reg    <= 4'd0;
      h_row_reg    <= '0;
      v_row_reg    <= '0;
      d_row_reg    <= '0;
      h_col_reg    <= '0;
      v_col_reg    <= '0;
      d_col_reg    <= '0;
      kind_h_reg   <= 4'd0;
      kind_v_reg   <= 4'd0;
      kind_d_reg   <= 4'd0;
    end else begin
      state_reg    <= state_next;
      map_en_reg   <= map_en_next;
      map_func_reg <= map_func_next;
      map_row_reg  <= map_row_next;
      map_col_reg  <= map_col_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      flip_x_reg   <= flip_x_next;
      flip_y_reg   <= flip_y_next;
      hit_kind_reg <= hit_kind_next;
      score_reg    <= score_next;
      if (state_reg == IDLE && start) begin
        h_row_reg  <= h_row_calc;
        h_col_reg  <= h_col_calc;
        v_row_reg  <= v_row_calc;
        v_col_reg  <= v_col_calc;
        d_row_reg  <= d_row_calc;
        d_col_reg  <= d_col_calc;
        kind_h_reg <= 4'd0;
        kind_v_reg <= 4'd0;
        kind_d_reg <= 4'd0;
      end
      if (state_reg == PROBE_H) kind_h_reg <= (|h_row_reg) ? cell_kind : 4'd0;
      if (state_reg == PROBE_V) kind_v_reg <= (|v_row_reg) ? cell_kind : 4'd0;
      if (state_reg == PROBE_D) kind_d_reg <= kd_fresh;
    end
  end

  assign map_en    = map_en_reg;
  assign map_func  = map_func_reg;
  assign map_row   = map_row_reg;
  assign map_col   = map_col_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign flip_x    = flip_x_reg;
  assign flip_y    = flip_y_reg;
  assign hit_kind  = hit_kind_reg;
  assign score_inc = score_reg;

endmodule

// File: tb/tb_brick_hit_ctrl.sv
// Bench for brick_hit_ctrl: a brick-map array answers probes, and a cell-level model of the
// collision rules predicts commands, latency, flips and score for directed and random frames.
module tb_brick_hit_ctrl;

  localparam int ROWS = 10, COLS = 20, X_OFF = 0, Y_OFF = 32;
  localparam int CELL_W = 32, CELL_H = 16, BALL_SZ = 8;

  logic            clock = 1'b0;
  logic            reset, start, dx_neg, dy_neg;
  logic [9:0]      ball_x, ball_y;
  logic [3:0]      cell_kind;
  logic            map_en, busy, done, flip_x, flip_y;
  logic [1:0]      map_func;
  logic [ROWS-1:0] map_row;
  logic [COLS-1:0] map_col;
  logic [3:0]      hit_kind, score_inc;

  brick_hit_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .BALL_SZ(BALL_SZ)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ball_x(ball_x), .ball_y(ball_y),
    .dx_neg(dx_neg), .dy_neg(dy_neg), .cell_kind(cell_kind), .map_en(map_en),
    .map_func(map_func), .map_row(map_row), .map_col(map_col), .busy(busy), .done(done),
    .flip_x(flip_x), .flip_y(flip_y), .hit_kind(hit_kind), .score_inc(score_inc)
  );

  always #5 clock = ~clock;

  logic [3:0] map_q [ROWS][COLS];

  // The brick map answers combinationally for a single selected cell.
  always_comb begin
    cell_kind = 4'd0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (map_row[r] && map_col[c] && $onehot(map_row) && $onehot(map_col))
          cell_kind = map_q[r][c];
  end

  int n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected results of one frame.
  logic [31:0] exp_psel [3];
  logic [31:0] exp_cmd [$];
  int          clr_r [$], clr_c [$];
  int          exp_lat, exp_ncmd;
  logic        exp_fx, exp_fy;
  logic [3:0]  exp_hk, exp_sc;

  function automatic int cell_c(input int x);
    int c;
    if (x < X_OFF) return -1;
    c = (x - X_OFF) / CELL_W;
    return (c >= COLS) ? -1 : c;
  endfunction

  function automatic int cell_r(input int y);
    int r;
    if (y < Y_OFF) return -1;
    r = (y - Y_OFF) / CELL_H;
    return (r >= ROWS) ? -1 : r;
  endfunction

  function automatic logic [31:0] sel_word(input int r, input int c);
    logic [ROWS-1:0] rr;
    logic [COLS-1:0] cc;
    rr = '0;
    cc = '0;
    if (r < 0 || c < 0) return 32'd0;
    rr[r] = 1'b1;
    cc[c] = 1'b1;
    return {2'b00, rr, cc};
  endfunction

  function automatic int points(input logic [3:0] k);
    case (k)
      4'b0001: return 1;
      4'b0010: return 5;
      4'b1000: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic add_clear(input int r, input int c, input logic [3:0] k,
                           inout int score, inout bit pull);
    exp_cmd.push_back(sel_word(r, c));
    clr_r.push_back(r);
    clr_c.push_back(c);
    score += points(k);
    if (k == 4'b1000) pull = 1'b1;
  endtask

  task automatic model_txn(input int x, input int y, input bit dxn, input bit dyn);
    int xl, xc, yl, yc, hr, hc, vr, vc, dr, dc, score;
    bit h_ok, v_ok, d_ok, pull;
    logic [3:0] kh, kv, kd;
    xl = dxn ? x : x + BALL_SZ - 1;
    yl = dyn ? y : y + BALL_SZ - 1;
    xc = x + BALL_SZ / 2 - 1;
    yc = y + BALL_SZ / 2 - 1;
    hr = cell_r(yc); hc = cell_c(xl);
    vr = cell_r(yl); vc = cell_c(xc);
    dr = cell_r(yl); dc = cell_c(xl);
    h_ok = hr >= 0 && hc >= 0;
    v_ok = vr >= 0 && vc >= 0;
    d_ok = dr >= 0 && dc >= 0;
    exp_psel[0] = h_ok ? sel_word(hr, hc) : 32'd0;
    exp_psel[1] = v_ok ? sel_word(vr, vc) : 32'd0;
    exp_psel[2] = d_ok ? sel_word(dr, dc) : 32'd0;
    kh = h_ok ? map_q[hr][hc] : 4'd0;
    kv = v_ok ? map_q[vr][vc] : 4'd0;
    kd = 4'd0;
    if (d_ok && !(dr == hr && dc == hc) && !(dr == vr && dc == vc) && kh == 0 && kv == 0)
      kd = map_q[dr][dc];
    exp_fx = (kh != 0) || (kd != 0);
    exp_fy = (kv != 0) || (kd != 0);
    exp_hk = kh | kv | kd;
    exp_cmd.delete();
    clr_r.delete();
    clr_c.delete();
    score = 0;
    pull = 1'b0;
    if (points(kh) > 0) add_clear(hr, hc, kh, score, pull);
    if (points(kv) > 0 && !(vr == hr && vc == hc)) add_clear(vr, vc, kv, score, pull);
    if (points(kd) > 0) add_clear(dr, dc, kd, score, pull);
    if (pull) exp_cmd.push_back({2'b11, 30'd0});
    exp_sc   = (score > 15) ? 4'd15 : 4'(score);
    exp_ncmd = exp_cmd.size();
    exp_lat  = 4 + exp_ncmd;
  endtask

  task automatic clear_map();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        map_q[r][c] = 4'd0;
  endtask

  int txn_no = 0;

  task automatic run_txn(input int x, input int y, input bit dxn, input bit dyn, input bit inj);
    int cyc, n_cmd;
    bit got_done;
    logic [31:0] obs;
    model_txn(x, y, dxn, dyn);
    @(negedge clock);
    ball_x = 10'(x); ball_y = 10'(y); dx_neg = dxn; dy_neg = dyn; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1; n_cmd = 0; got_done = 1'b0;
    while (!got_done && cyc <= 12) begin
      obs = {map_func, map_row, map_col};
      if (cyc <= 3) begin
        check_val($sformatf("probe%0d_sel", cyc), obs, exp_psel[cyc-1]);
        check_val($sformatf("probe%0d_en", cyc), {31'd0, map_en}, 32'd0);
      end
      if (done) begin
        got_done = 1'b1;
        check_val("latency", cyc, exp_lat);
        check_val("busy_at_done", {31'd0, busy}, 32'd0);
        check_val("flip_x", {31'd0, flip_x}, {31'd0, exp_fx});
        check_val("flip_y", {31'd0, flip_y}, {31'd0, exp_fy});
        check_val("hit_kind", {28'd0, hit_kind}, {28'd0, exp_hk});
        check_val("score_inc", {28'd0, score_inc}, {28'd0, exp_sc});
      end else begin
        check_val("busy", {31'd0, busy}, 32'd1);
        if (map_en) begin
          n_cmd++;
          if (exp_cmd.size() == 0) check_val("cmd_extra", {31'd0, map_en}, 32'd0);
          else check_val("cmd", obs, exp_cmd.pop_front());
        end
      end
      if (!got_done) begin
        start = inj && (cyc == 2);
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    if (!got_done) check_val("done_timeout", {31'd0, done}, 32'd1);
    check_val("cmd_count", n_cmd, exp_ncmd);
    @(negedge clock);
    check_val("post_done", {29'd0, busy, done, map_en}, 32'd0);
    for (int i = 0; i < clr_r.size(); i++) map_q[clr_r[i]][clr_c[i]] = 4'd0;
    txn_no++;
    $display("txn %0d x=%0d y=%0d dxn=%0d dyn=%0d cmds=%0d lat=%0d score=%0d",
             txn_no, x, y, dxn, dyn, n_cmd, cyc, score_inc);
  endtask

  function automatic logic [3:0] rand_kind();
    case ($urandom_range(0, 7))
      3: return 4'b0001;
      4: return 4'b0010;
      5: return 4'b0100;
      6: return 4'b1000;
      7: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    int n_done;
    reset = 1'b1; start = 1'b0; ball_x = '0; ball_y = '0; dx_neg = 1'b0; dy_neg = 1'b0;
    clear_map();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("reset_ctl", {19'd0, map_en, map_func, busy, done, flip_x, flip_y, hit_kind, score_inc}, 32'd0);
    check_val("reset_sel", {2'b00, map_row, map_col}, 32'd0);

    // Directed frames from the block description.
    run_txn(100, 60, 1'b0, 1'b0, 1'b0);
    map_q[2][3] = 4'b0001;
    run_txn(100, 60, 1'b0, 1'b0, 1'b1);
    clear_map(); map_q[1][3] = 4'b0010;
    run_txn(92, 44, 1'b0, 1'b0, 1'b0);
    clear_map(); map_q[0][3] = 4'b0100;
    run_txn(92, 44, 1'b0, 1'b0, 1'b1);
    clear_map(); map_q[1][2] = 4'b1000;
    run_txn(92, 44, 1'b0, 1'b0, 1'b0);
    clear_map();
    for (int c = 0; c < COLS; c++) map_q[ROWS-1][c] = 4'b0001;
    run_txn(100, 300, 1'b0, 1'b1, 1'b0);
    run_txn(0, 0, 1'b1, 1'b1, 1'b0);

    // Reset while the second clear (V) is on the bus: no done may follow.
    clear_map(); map_q[1][3] = 4'b0001; map_q[2][3] = 4'b0001;
    @(negedge clock);
    ball_x = 10'd100; ball_y = 10'd60; dx_neg = 1'b0; dy_neg = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check_val("rst_clr_v", {map_en, map_func, map_row, map_col}, {1'b1, 2'b00, 10'h004, 20'h00008});
    reset = 1'b1;
    @(negedge clock);
    check_val("rst_mid_ctl", {19'd0, map_en, map_func, busy, done, flip_x, flip_y, hit_kind, score_inc}, 32'd0);
    check_val("rst_mid_sel", {2'b00, map_row, map_col}, 32'd0);
    reset = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge clock);
      if (done || busy) n_done++;
    end
    check_val("rst_no_done", n_done, 0);
    clear_map();

    // Random frames over randomly filled maps.
    for (int t = 0; t < 60; t++) begin
      if (t % 10 == 0)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            map_q[r][c] = rand_kind();
      run_txn(int'($urandom_range(0, 700)), int'($urandom_range(0, 230)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
